chart_sequencer: RTL and testbench



---
 rtl/chart_sequencer_pkg.sv | 46 ++++
 rtl/chart_sequencer_tick_divider.sv | 44 ++++
 rtl/chart_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_chart_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chart_sequencer_pkg.sv
// Shared widths, FSM state encodings, mod encodings and tick-period helper for chart_sequencer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package chart_sequencer_pkg;

    // Default field widths of one chart entry and of the score datapath
    localparam int CS_CLOCK_BITS  = 16;
    localparam int CS_OCTAVE_BITS = 2;
    localparam int CS_NOTE_BITS   = 3;
    localparam int CS_LENGTH_BITS = 3;
    localparam int CS_MAX_NUM     = 32;
    localparam int CS_ADDR_BITS   = 8;

    // A chart entry is packed {clock, octave, note, length}, length in the LSBs
    localparam int CS_LEN_LSB  = 0;
    localparam int CS_NOTE_LSB = CS_LEN_LSB + CS_LENGTH_BITS;
    localparam int CS_OCT_LSB  = CS_NOTE_LSB + CS_NOTE_BITS;
    localparam int CS_CLK_LSB  = CS_OCT_LSB + CS_OCTAVE_BITS;

    // Sequencer FSM encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_JUDGE  = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Game modifier encodings
    localparam logic [1:0] MOD_NORMAL = 2'b00;
    localparam logic [1:0] MOD_NOFAIL = 2'b01;
    localparam logic [1:0] MOD_HALF   = 2'b10;
    localparam logic [1:0] MOD_DOUBLE = 2'b11;

    // clk cycles per game tick for a given modifier; never below one cycle
    function automatic int tick_period(input logic [1:0] mod, input int div);
        int p;
        case (mod)
            MOD_HALF:   p = 2 * div;
            MOD_DOUBLE: p = div / 2;
            default:    p = div;
        endcase
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/chart_sequencer_tick_divider.sv
// Game-tick enable generator: one-cycle tick every tick_period(mod) enabled cycles.
// Latency: tick asserted combinationally in the last cycle of each period.
// Backpressure: run=0 freezes the count in place; clr restarts the period.
module chart_sequencer_tick_divider
    import chart_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       run,
    input  logic [1:0] mod,
    output logic       tick
);

    localparam int CNT_BITS = $clog2(2 * TICK_DIV + 1);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic [CNT_BITS-1:0] last_cnt;

    // Terminal count follows mod live; >= keeps a mid-period switch to a shorter period safe
    always_comb begin
        last_cnt = CNT_BITS'(tick_period(mod, TICK_DIV) - 1);
        tick     = run && (cnt_q >= last_cnt);
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CNT_BITS'(1);
        end
    end

    // Period counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chart_sequencer.sv
// Chart player: fetches goal notes, pairs them with player hits for Scoring, folds results back. Optional fail-out: CHART_FAIL_EN.
// Latency: hit pulse in WAIT -> JUDGE -> judge_valid in COMMIT (3 cycles); ROM read 1 cycle.
// Backpressure: none; pause freezes the timeline and masks hits, start is ignored while busy.
module chart_sequencer
    import chart_sequencer_pkg::*;
#(
    parameter int CLOCK_BITS  = CS_CLOCK_BITS,
    parameter int OCTAVE_BITS = CS_OCTAVE_BITS,
    parameter int NOTE_BITS   = CS_NOTE_BITS,
    parameter int LENGTH_BITS = CS_LENGTH_BITS,
    parameter int MAX_NUM     = CS_MAX_NUM,
    parameter int ADDR_BITS   = CS_ADDR_BITS,
    parameter int TICK_DIV    = 100000,
    parameter int MISS_WINDOW = 188
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic [1:0]             mod,
    input  logic [MAX_NUM-1:0]     song_len,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [CLOCK_BITS+OCTAVE_BITS+NOTE_BITS+LENGTH_BITS-1:0] rom_data,
    input  logic                   hit_valid,
    input  logic [OCTAVE_BITS-1:0] hit_octave,
    input  logic [NOTE_BITS-1:0]   hit_note,
    input  logic [LENGTH_BITS-1:0] hit_length,
    output logic [CLOCK_BITS-1:0]  song_clock,
    output logic [OCTAVE_BITS-1:0] play_octave,
    output logic [NOTE_BITS-1:0]   play_note,
    output logic [LENGTH_BITS-1:0] play_length,
    output logic [CLOCK_BITS-1:0]  goal_clock,
    output logic [OCTAVE_BITS-1:0] goal_octave,
    output logic [NOTE_BITS-1:0]   goal_note,
    output logic [LENGTH_BITS-1:0] goal_length,
    output logic [MAX_NUM-1:0]     last_combo,
    output logic [MAX_NUM-1:0]     last_base_score,
    output logic [MAX_NUM-1:0]     now_cnt,
    output logic [MAX_NUM-1:0]     total_note,
    input  logic [MAX_NUM-1:0]     base_score,
    input  logic [MAX_NUM-1:0]     bonus_score,
    input  logic [MAX_NUM-1:0]     combo,
    output logic [MAX_NUM-1:0]     total_score,
    output logic                   judge_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   failed
);

    localparam int NOTE_LSB = LENGTH_BITS;
    localparam int OCT_LSB  = NOTE_LSB + NOTE_BITS;
    localparam int CLK_LSB  = OCT_LSB + OCTAVE_BITS;
    localparam logic [CLOCK_BITS:0] WIN = (CLOCK_BITS + 1)'(MISS_WINDOW);

    logic [2:0]             state_q, state_d;
    logic [CLOCK_BITS-1:0]  song_clock_q, song_clock_d;
    logic [CLOCK_BITS-1:0]  goal_clock_q, goal_clock_d;
    logic [OCTAVE_BITS-1:0] goal_octave_q, goal_octave_d, play_octave_q, play_octave_d;
    logic [NOTE_BITS-1:0]   goal_note_q, goal_note_d, play_note_q, play_note_d;
    logic [LENGTH_BITS-1:0] goal_length_q, goal_length_d, play_length_q, play_length_d;
    logic [MAX_NUM-1:0]     last_combo_q, last_combo_d, last_base_q, last_base_d;
    logic [MAX_NUM-1:0]     now_cnt_q, now_cnt_d, total_note_q, total_note_d;
    logic [MAX_NUM-1:0]     total_score_q, total_score_d;
`ifdef CHART_FAIL_EN
    logic [3:0]             miss_cnt_q, miss_cnt_d;
    logic                   failed_q, failed_d;
`endif
    logic                   idle_or_done, run, tick, hit_ok, miss;

    function automatic logic [MAX_NUM-1:0] sat_add(input logic [MAX_NUM-1:0] a,
                                                   input logic [MAX_NUM-1:0] b);
        logic [MAX_NUM:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[MAX_NUM] ? '1 : s[MAX_NUM-1:0];
    endfunction

    // Status decode and hit/miss window compares, one bit wider so they cannot wrap
    always_comb begin
        idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
        run          = !idle_or_done && !pause;
        hit_ok       = hit_valid && !pause &&
                       ({1'b0, goal_clock_q} <= {1'b0, song_clock_q} + WIN);
        miss         = {1'b0, song_clock_q} > {1'b0, goal_clock_q} + WIN;
    end

    chart_sequencer_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (start && idle_or_done),
        .run  (run),
        .mod  (mod),
        .tick (tick)
    );

    // Sequencer FSM plus timeline, goal/play capture and score accumulation
    always_comb begin
        state_d       = state_q;
        song_clock_d  = song_clock_q;
        goal_clock_d  = goal_clock_q;
        goal_octave_d = goal_octave_q;
        goal_note_d   = goal_note_q;
        goal_length_d = goal_length_q;
        play_octave_d = play_octave_q;
        play_note_d   = play_note_q;
        play_length_d = play_length_q;
        last_combo_d  = last_combo_q;
        last_base_d   = last_base_q;
        now_cnt_d     = now_cnt_q;
        total_note_d  = total_note_q;
        total_score_d = total_score_q;
`ifdef CHART_FAIL_EN
        miss_cnt_d    = miss_cnt_q;
        failed_d      = failed_q;
`endif
        if (tick && (song_clock_q != '1)) begin
            song_clock_d = song_clock_q + CLOCK_BITS'(1);
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    song_clock_d  = '0;
                    now_cnt_d     = '0;
                    last_combo_d  = '0;
                    last_base_d   = '0;
                    total_score_d = '0;
                    total_note_d  = song_len;
`ifdef CHART_FAIL_EN
                    miss_cnt_d    = '0;
                    failed_d      = 1'b0;
`endif
                    state_d = (song_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                goal_clock_d  = rom_data[CLK_LSB +: CLOCK_BITS];
                goal_octave_d = rom_data[OCT_LSB +: OCTAVE_BITS];
                goal_note_d   = rom_data[NOTE_LSB +: NOTE_BITS];
                goal_length_d = rom_data[0 +: LENGTH_BITS];
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                // A hit in the same cycle as the miss deadline takes priority
                if (hit_ok) begin
                    play_octave_d = hit_octave;
                    play_note_d   = hit_note;
                    play_length_d = hit_length;
`ifdef CHART_FAIL_EN
                    miss_cnt_d    = '0;
`endif
                    state_d       = ST_JUDGE;
                end else if (miss) begin
                    last_combo_d = '0;
                    state_d      = ST_COMMIT;
`ifdef CHART_FAIL_EN
                    if (miss_cnt_q != 4'hF) begin
                        miss_cnt_d = miss_cnt_q + 4'd1;
                    end
                    if ((miss_cnt_d == 4'd10) && (mod != MOD_NOFAIL)) begin
                        failed_d = 1'b1;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_JUDGE: begin
                last_combo_d  = combo;
                last_base_d   = sat_add(last_base_q, base_score);
                total_score_d = sat_add(sat_add(total_score_q, base_score), bonus_score);
                state_d       = ST_COMMIT;
            end
            ST_COMMIT: begin
                now_cnt_d = now_cnt_q + MAX_NUM'(1);
                state_d   = (now_cnt_d == total_note_q) ? ST_DONE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any song in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            song_clock_q  <= '0;
            goal_clock_q  <= '0;
            goal_octave_q <= '0;
            goal_note_q   <= '0;
            goal_length_q <= '0;
            play_octave_q <= '0;
            play_note_q   <= '0;
            play_length_q <= '0;
            last_combo_q  <= '0;
            last_base_q   <= '0;
            now_cnt_q     <= '0;
            total_note_q  <= '0;
            total_score_q <= '0;
`ifdef CHART_FAIL_EN
            miss_cnt_q    <= '0;
            failed_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            song_clock_q  <= song_clock_d;
            goal_clock_q  <= goal_clock_d;
            goal_octave_q <= goal_octave_d;
            goal_note_q   <= goal_note_d;
            goal_length_q <= goal_length_d;
            play_octave_q <= play_octave_d;
            play_note_q   <= play_note_d;
            play_length_q <= play_length_d;
            last_combo_q  <= last_combo_d;
            last_base_q   <= last_base_d;
            now_cnt_q     <= now_cnt_d;
            total_note_q  <= total_note_d;
            total_score_q <= total_score_d;
`ifdef CHART_FAIL_EN
            miss_cnt_q    <= miss_cnt_d;
            failed_q      <= failed_d;
`endif
        end
    end

    assign rom_addr        = now_cnt_q[ADDR_BITS-1:0];
    assign song_clock      = song_clock_q;
    assign goal_clock      = goal_clock_q;
    assign goal_octave     = goal_octave_q;
    assign goal_note       = goal_note_q;
    assign goal_length     = goal_length_q;
    assign play_octave     = play_octave_q;
    assign play_note       = play_note_q;
    assign play_length     = play_length_q;
    assign last_combo      = last_combo_q;
    assign last_base_score = last_base_q;
    assign now_cnt         = now_cnt_q;
    assign total_note      = total_note_q;
    assign total_score     = total_score_q;
    assign judge_valid     = (state_q == ST_COMMIT);
    assign busy            = !idle_or_done;
    assign done            = (state_q == ST_DONE);
`ifdef CHART_FAIL_EN
    assign failed          = failed_q;
`else
    assign failed          = 1'b0;
`endif

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer with a behavioural ROM, a stand-in Scoring block and a commit scoreboard.
// Latency: checks hit-to-judge_valid of 3 cycles and tick periods per mod.
// Backpressure: exercises pause freeze, ignored start and reset mid-judge.
module tb_chart_sequencer;

    logic        clk, rst, start, pause, hit_valid;
    logic [1:0]  mod, hit_octave, play_octave, goal_octave;
    logic [2:0]  hit_note, hit_length, play_note, play_length, goal_note, goal_length;
    logic [31:0] song_len, last_combo, last_base_score, now_cnt, total_note;
    logic [31:0] base_score, bonus_score, combo, total_score;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [15:0] song_clock, goal_clock;
    logic        judge_valid, busy, done, failed;

    logic [23:0] rom [0:255];

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] cmb;
        logic [31:0] base;
        logic [31:0] total;
        bit          chk_clk;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   n_judge   = 0;

    chart_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .mod(mod),
        .song_len(song_len), .rom_addr(rom_addr), .rom_data(rom_data),
        .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note),
        .hit_length(hit_length), .song_clock(song_clock),
        .play_octave(play_octave), .play_note(play_note), .play_length(play_length),
        .goal_clock(goal_clock), .goal_octave(goal_octave), .goal_note(goal_note),
        .goal_length(goal_length), .last_combo(last_combo),
        .last_base_score(last_base_score), .now_cnt(now_cnt), .total_note(total_note),
        .base_score(base_score), .bonus_score(bonus_score), .combo(combo),
        .total_score(total_score), .judge_valid(judge_valid), .busy(busy),
        .done(done), .failed(failed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous chart ROM
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Stand-in Scoring: +2 combo per judged note, 100 for a matching note, bonus = previous combo
    always_comb begin
        combo       = last_combo + 32'd2;
        base_score  = (play_note == goal_note && play_octave == goal_octave) ? 32'd100 : 32'd0;
        bonus_score = last_combo;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every judge_valid pops the oldest expected commit
    always @(negedge clk) begin
        if (judge_valid === 1'b1) begin
            n_judge++;
            if (sb.size() == 0) begin
                check("unexpected_judge", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check("judge_now_cnt", now_cnt, got.cnt);
                check("judge_last_combo", last_combo, got.cmb);
                check("judge_last_base", last_base_score, got.base);
                check("judge_total_score", total_score, got.total);
                if (got.chk_clk) check("judge_miss_clock", 32'(song_clock), 32'(got.sc));
            end
        end
    end

    task automatic push(input logic [31:0] c, input logic [31:0] cb, input logic [31:0] b,
                        input logic [31:0] t, input bit ck, input logic [15:0] sc);
        exp_t e;
        e.cnt = c; e.cmb = cb; e.base = b; e.total = t; e.chk_clk = ck; e.sc = sc;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic hit(input logic [1:0] o, input logic [2:0] n, input logic [2:0] l);
        hit_octave = o; hit_note = n; hit_length = l; hit_valid = 1'b1;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    task automatic wait_sc(input logic [15:0] tgt, input int budget, input string tag);
        int i;
        i = 0;
        while (song_clock !== tgt && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(song_clock), 32'(tgt));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic measure(output int period);
        logic [15:0] p;
        int i;
        p = song_clock; i = 0;
        while (song_clock == p && i < 40) begin @(negedge clk); i++; end
        p = song_clock; period = 0;
        while (song_clock == p && period < 40) begin @(negedge clk); period++; end
    endtask

    initial begin
        logic [23:0] e;
        logic [31:0] exp_cmb, exp_base, exp_total;
        logic [15:0] sc_p;
        int          per, n_exp;
        logic [31:0] exp_failed;

        rst = 1'b1; start = 1'b0; pause = 1'b0; mod = 2'b00; song_len = '0;
        hit_valid = 1'b0; hit_octave = '0; hit_note = '0; hit_length = '0;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_song_clock", 32'(song_clock), 32'd0);
        check("rst_now_cnt", now_cnt, 32'd0);
        check("rst_total_score", total_score, 32'd0);
        check("rst_judge_valid", 32'(judge_valid), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_failed", 32'(failed), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Song A: three notes hit exactly on their goal clocks
        rom[0] = {16'd10, 2'd1, 3'd2, 3'd3};
        rom[1] = {16'd20, 2'd2, 3'd5, 3'd1};
        rom[2] = {16'd30, 2'd0, 3'd7, 3'd4};
        song_len = 32'd3;
        pulse_start();
        exp_cmb = 0; exp_base = 0; exp_total = 0;
        for (int k = 0; k < 3; k++) begin
            e = rom[k];
            wait_sc(e[23:8], 400, "A_reach_goal");
            check("A_goal_clock", 32'(goal_clock), 32'(e[23:8]));
            exp_total = exp_total + 32'd100 + exp_cmb;
            exp_cmb   = exp_cmb + 32'd2;
            exp_base  = exp_base + 32'd100;
            push(32'(k), exp_cmb, exp_base, exp_total, 1'b0, '0);
            hit(e[7:6], e[5:3], e[2:0]);
            check("A_play_note", 32'(play_note), 32'(e[5:3]));
            @(negedge clk);
            check("A_hit_latency", 32'(judge_valid), 32'd1);
        end
        wait_done(50, "A_done");
        check("A_now_cnt", now_cnt, 32'd3);
        check("A_last_combo", last_combo, 32'd6);
        check("A_last_base", last_base_score, 32'd300);
        check("A_total_score", total_score, 32'd306);
        check("A_total_note", total_note, 32'd3);
        check("A_busy", 32'(busy), 32'd0);
        check("A_judges", 32'(n_judge), 32'd3);

        // Song C: restart from DONE, no hits, both notes miss
        rom[0] = {16'd10, 2'd0, 3'd1, 3'd1};
        rom[1] = {16'd20, 2'd0, 3'd2, 3'd1};
        song_len = 32'd2;
        push(32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 16'd199);
        push(32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 16'd209);
        pulse_start();
        wait_done(1200, "C_done");
        check("C_total_score", total_score, 32'd0);
        check("C_last_combo", last_combo, 32'd0);
        check("C_now_cnt", now_cnt, 32'd2);
        check("C_failed", 32'(failed), 32'd0);
        check("C_judges", 32'(n_judge), 32'd5);

        // Empty chart finishes immediately
        song_len = 32'd0;
        pulse_start();
        check("Z_done", 32'(done), 32'd1);
        check("Z_busy", 32'(busy), 32'd0);
        check("Z_total_note", total_note, 32'd0);

        // Song B: early hits ignored, start ignored while busy, pause freezes timeline
        rom[0] = {16'd400, 2'd1, 3'd4, 3'd2};
        song_len = 32'd1;
        pulse_start();
        repeat (5) @(negedge clk);
        hit(2'd1, 3'd4, 3'd2);
        repeat (3) @(negedge clk);
        check("B_early_now_cnt", now_cnt, 32'd0);
        check("B_early_busy", 32'(busy), 32'd1);
        check("B_early_judges", 32'(n_judge), 32'd5);
        sc_p = song_clock;
        pulse_start();
        check("B_start_ignored", 32'(song_clock >= sc_p && sc_p != 0), 32'd1);
        wait_sc(16'd211, 1000, "B_reach_211");
        hit(2'd1, 3'd4, 3'd2);
        repeat (3) @(negedge clk);
        check("B_edge_judges", 32'(n_judge), 32'd5);
        wait_sc(16'd215, 50, "B_reach_215");
        pause = 1'b1;
        sc_p = song_clock;
        hit(2'd1, 3'd4, 3'd2);
        repeat (49) @(negedge clk);
        check("B_pause_frozen", 32'(song_clock), 32'(sc_p));
        check("B_pause_judges", 32'(n_judge), 32'd5);
        pause = 1'b0;
        repeat (8) @(negedge clk);
        check("B_resume", 32'(song_clock), 32'(sc_p + 16'd2));
        push(32'd0, 32'd2, 32'd100, 32'd100, 1'b0, '0);
        hit(2'd1, 3'd4, 3'd2);
        @(negedge clk);
        check("B_hit_latency", 32'(judge_valid), 32'd1);
        wait_done(20, "B_done");
        check("B_judges", 32'(n_judge), 32'd6);

        // Song D: tick period by mod, then reset while in JUDGE
        rom[0] = '0;
        song_len = 32'd1;
        mod = 2'b11;
        pulse_start();
        measure(per);
        check("D_double_period", 32'(per), 32'd2);
        mod = 2'b10;
        measure(per);
        check("D_half_period", 32'(per), 32'd8);
        mod = 2'b00;
        hit(2'd0, 3'd0, 3'd0);
        rst = 1'b1;
        @(negedge clk);
        check("R_busy", 32'(busy), 32'd0);
        check("R_done", 32'(done), 32'd0);
        check("R_judge_valid", 32'(judge_valid), 32'd0);
        check("R_song_clock", 32'(song_clock), 32'd0);
        check("R_total_note", total_note, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("R_judges", 32'(n_judge), 32'd6);
        check("R_idle_busy", 32'(busy), 32'd0);

        // Long miss streak: fails out when the fail feature is built in
`ifdef CHART_FAIL_EN
        n_exp = 9; exp_failed = 32'd1;
`else
        n_exp = 12; exp_failed = 32'd0;
`endif
        for (int i = 0; i < 12; i++) rom[i] = '0;
        song_len = 32'd12;
        for (int i = 0; i < n_exp; i++) push(32'(i), 32'd0, 32'd0, 32'd0, 1'b0, '0);
        pulse_start();
        wait_done(1500, "F_done");
        check("F_failed", 32'(failed), exp_failed);
        check("F_now_cnt", now_cnt, 32'(n_exp));
        check("F_judges", 32'(n_judge), 32'(6 + n_exp));
        check("F_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
